// File: rtl/binary_mul_pkg.sv
// Shared definitions for the 6x6 multiplier issue/capture controller.
//   WIDTH        operand width (product is 2*WIDTH)
//   MUL_LATENCY  clock edges from stable operands to a fully settled product
//   state_e      controller state encoding
//   cnt_width()  latency counter width for a given latency
package binary_mul_pkg;

  localparam int WIDTH       = 6;
  localparam int MUL_LATENCY = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int latency);
    return $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/mul_lat_cnt.sv
// Loadable latency down-counter.
//   clk_i       clock
//   rst_n_i     asynchronous active-low reset (count clears to 0)
//   load_i      load load_val_i (has priority over dec_i)
//   load_val_i  value to load
//   dec_i       decrement by one; saturates at zero
//   zero_o      count is zero
module mul_lat_cnt #(
  parameter int CW = 3
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          dec_i,
  output logic          zero_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/binary_mul_6_issue_ctrl.sv
// Operand-issue / result-capture controller for the row-pipelined 6x6
// unsigned array multiplier. Accepts one operand pair, holds it on mul_a/mul_b
// for the multiplier's full settling time, then captures the product and
// offers it on a valid/ready output. One transaction in flight at a time.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          operand handshake; in_a, in_b operands
//   mul_a, mul_b, mul_en       operands and enable to the multiplier
//   mul_p                      product from the multiplier
//   out_valid/out_ready        result handshake; out_p registered product
//   chk_err                    only with BINARY_MUL_SELF_CHECK_EN: sticky flag,
//                              set when the captured product differs from the
//                              behavioural a*b
//
// States:
//   IDLE | waiting for an operand pair, in_ready=1
//   RUN  | operands held, waiting for the product to settle, mul_en=1
//   DONE | result held on out_p until out_ready
module binary_mul_6_issue_ctrl
  import binary_mul_pkg::*;
#(
  parameter int WIDTH       = binary_mul_pkg::WIDTH,
  parameter int MUL_LATENCY = binary_mul_pkg::MUL_LATENCY
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic               mul_en,
  input  logic [2*WIDTH-1:0] mul_p,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p
`ifdef BINARY_MUL_SELF_CHECK_EN
  ,
  output logic               chk_err
`endif
);

  localparam int CW = cnt_width(MUL_LATENCY);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] out_p_q;
  logic               out_valid_q;
  logic               cnt_zero;
  logic               accept;
  logic               capture;

  assign accept  = (state_q == IDLE) && in_valid;
  // The counter reaches zero one edge before capture, so every pipeline
  // row has been recomputed from the held operands when mul_p is sampled.
  assign capture = (state_q == RUN) && cnt_zero;

  mul_lat_cnt #(.CW(CW)) u_lat_cnt (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .load_i     (accept),
    .load_val_i (CW'(MUL_LATENCY)),
    .dec_i      (state_q == RUN),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    mul_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        mul_en = 1'b1;
        if (cnt_zero) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      out_p_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q <= in_a;
        b_q <= in_b;
      end
      if (capture) begin
        out_p_q     <= mul_p;
        out_valid_q <= 1'b1;
      end else if ((state_q == DONE) && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign out_p     = out_p_q;
  assign out_valid = out_valid_q;

`ifdef BINARY_MUL_SELF_CHECK_EN
  logic               chk_err_q;
  logic [2*WIDTH-1:0] ref_p;

  assign ref_p = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err_q <= 1'b0;
    end else if (capture && (mul_p != ref_p)) begin
      chk_err_q <= 1'b1;
    end
  end

  assign chk_err = chk_err_q;
`endif

endmodule

// File: tb/tb_binary_mul_6_issue_ctrl.sv
module tb_binary_mul_6_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_a = '0, in_b = '0;
  logic [5:0]  mul_a, mul_b;
  logic        mul_en;
  logic [11:0] mul_p;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_p;
`ifdef BINARY_MUL_SELF_CHECK_EN
  logic        chk_err;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  binary_mul_6_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_en(mul_en), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p)
`ifdef BINARY_MUL_SELF_CHECK_EN
    , .chk_err(chk_err)
`endif
  );

  // Multiplier stand-in: product of the presented operands, visible only after
  // 7 edges; stale values are visible before that. flip corrupts bit 6.
  logic [11:0] pipe [7];
  logic        flip = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 7; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {6'b0, mul_a} * {6'b0, mul_b};
      for (int i = 1; i < 7; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign mul_p = pipe[6] ^ (flip ? 12'h040 : 12'h000);

  // Behavioural model: a transaction accepted at cycle N presents its result
  // from cycle N+8 until taken; the block is busy from accept until taken.
  int          cyc = 0;
  bit          m_busy = 0, m_ov = 0, m_chk = 0;
  int          m_acc = 0, m_gap = 0, n_acc = 0;
  logic [11:0] m_prod = '0, m_p = '0;
  logic [5:0]  m_a = '0, m_b = '0;
  bit          m_flip = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_ov = 0; m_chk = 0; m_p = '0; m_a = '0; m_b = '0;
    end else begin
      cyc++;
      if (m_busy) begin
        if (m_ov) begin
          if (out_ready) begin m_busy = 0; m_ov = 0; end
        end else if (cyc - m_acc == 8) begin
          m_ov = 1;
          m_p  = m_prod ^ (flip ? 12'h040 : 12'h000);
          if (flip) m_chk = 1;
        end
      end else if (in_valid) begin
        m_busy = 1;
        m_gap  = cyc - m_acc;
        m_acc  = cyc;
        n_acc++;
        m_a    = in_a;
        m_b    = in_b;
        m_prod = 12'(int'(in_a) * int'(in_b));
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("in_ready",  int'(in_ready),  int'(!m_busy));
    chk("mul_en",    int'(mul_en),    int'(m_busy && !m_ov));
    chk("out_valid", int'(out_valid), int'(m_ov));
    chk("out_p",     int'(out_p),     int'(m_p));
    chk("mul_a",     int'(mul_a),     int'(m_a));
    chk("mul_b",     int'(mul_b),     int'(m_b));
`ifdef BINARY_MUL_SELF_CHECK_EN
    chk("chk_err",   int'(chk_err),   int'(m_chk));
`endif
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Issue one pair from IDLE, return cycles from accept to out_valid.
  task automatic issue(input int a, input int b, input bit rdy, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin step(); n++; end
    in_a = 6'(a); in_b = 6'(b); in_valid = 1'b1; out_ready = rdy;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 30) begin step(); lat++; end
  endtask

  initial begin
    int lat, start_acc, n;
    rst_n = 1'b0;
    step(); step();
    chk("reset in_ready",  int'(in_ready), 1);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset out_p",     int'(out_p), 0);
    chk("reset mul_en",    int'(mul_en), 0);
    rst_n = 1'b1;
    step();

    issue(63, 63, 1'b1, lat);
    chk("lat 63*63", lat, 8);
    chk("p 63*63", int'(out_p), 12'hF81);
    step();

    issue(45, 27, 1'b1, lat); chk("p 45*27", int'(out_p), 1215); step();
    issue(0, 55, 1'b1, lat);  chk("p 0*55",  int'(out_p), 0);    step();
    issue(1, 63, 1'b1, lat);  chk("p 1*63",  int'(out_p), 63);   step();
    issue(32, 2, 1'b1, lat);  chk("p 32*2",  int'(out_p), 64);   step();

    // Result held under back-pressure; further pairs refused.
    issue(45, 27, 1'b0, lat);
    in_valid = 1'b1; in_a = 6'd3; in_b = 6'd3;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("hold p", int'(out_p), 1215);
      chk("hold ov", int'(out_valid), 1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("idle after take", int'(in_ready), 1);

    // Reset in the middle of RUN.
    in_a = 6'd7; in_b = 6'd9; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    chk("mid-run rst ov", int'(out_valid), 0);
    chk("mid-run rst rdy", int'(in_ready), 1);
    chk("mid-run rst en", int'(mul_en), 0);
    chk("mid-run rst a", int'(mul_a), 0);
    step(); step();
    rst_n = 1'b1;
    step();
    issue(5, 5, 1'b1, lat);
    chk("p 5*5", int'(out_p), 25);
    step();

    // Streaming with in_valid held high and random operands.
    start_acc = n_acc;
    in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (n_acc - start_acc < 200 && n < 3000) begin
      int prev;
      in_a = 6'($urandom_range(0, 63));
      in_b = 6'($urandom_range(0, 63));
      prev = n_acc;
      step();
      n++;
      if (n_acc != prev && n_acc - start_acc > 1) chk("stream period", m_gap, 10);
    end
    chk("stream done", int'(n_acc - start_acc >= 200), 1);
    in_valid = 1'b0;
    n = 0;
    while (!in_ready && n < 30) begin step(); n++; end
    step();

`ifdef BINARY_MUL_SELF_CHECK_EN
    chk("chk_err clear", int'(chk_err), 0);
    flip = 1'b1;
    issue(21, 13, 1'b1, lat);
    chk("chk_err set", int'(chk_err), 1);
    step();
    flip = 1'b0;
    issue(2, 3, 1'b1, lat);
    chk("chk_err sticky", int'(chk_err), 1);
    step();
    rst_n = 1'b0;
    step();
    chk("chk_err reset", int'(chk_err), 0);
    rst_n = 1'b1;
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
